// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file.
// Default geometry, zero-register address and write-port decode.
package regfile_pkg;

  localparam int REGAW_DEF = 4;
  localparam int REGDW_DEF = 16;
  localparam int NRP_DEF   = 2;
  localparam int ZERO_ADDR = 0;

  // Widest address the decode helper accepts.
  localparam int MAX_AW   = 8;
  localparam int MAX_REGS = 2**MAX_AW;

  // One-hot select for a write or issue port.
  // Out-of-range and masked zero-register targets decode to all zeros.
  function automatic logic [MAX_REGS-1:0] wr_onehot(
    input logic              en,
    input logic [MAX_AW-1:0] addr,
    input int                regn,
    input logic              zero_reg
  );
    logic [MAX_REGS-1:0] hot;
    hot = '0;
    if (en && (int'(addr) < regn) &&
        !(zero_reg && (int'(addr) == ZERO_ADDR)))
      hot[addr] = 1'b1;
    return hot;
  endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// One registered read port: range check, W1/W0/rf bypass, enable-gated flops.
// Ports: clock/reset, RdEn_i/RdAddr_i, both write ports, Rf_i storage,
//        BusyNxt_i post-edge scoreboard, RdData_o/RdBusy_o registered.
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int REGAW    = REGAW_DEF,
  parameter int REGDW    = REGDW_DEF,
  parameter int REGN     = 2**REGAW,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                       Clk_i,
  input  logic                       Rst_n_i,
  input  logic                       RdEn_i,
  input  logic [REGAW-1:0]           RdAddr_i,
  input  logic                       W0En_i,
  input  logic [REGAW-1:0]           W0Addr_i,
  input  logic [REGDW-1:0]           W0Data_i,
  input  logic                       W1En_i,
  input  logic [REGAW-1:0]           W1Addr_i,
  input  logic [REGDW-1:0]           W1Data_i,
  input  logic [REGN-1:0][REGDW-1:0] Rf_i,
  input  logic [REGN-1:0]            BusyNxt_i,
  output logic [REGDW-1:0]           RdData_o,
  output logic                       RdBusy_o
);

  logic             valid;
  logic [REGDW-1:0] data_nxt;
  logic             busy_nxt;

  always_comb begin
    valid    = (32'(RdAddr_i) < 32'(REGN)) &&
               !(ZERO_REG && (32'(RdAddr_i) == 32'(ZERO_ADDR)));
    data_nxt = '0;
    busy_nxt = 1'b0;
    if (valid) begin
      busy_nxt = BusyNxt_i[RdAddr_i];
      // W1 wins over W0, matching the storage write priority.
      if (W1En_i && (W1Addr_i == RdAddr_i))
        data_nxt = W1Data_i;
      else if (W0En_i && (W0Addr_i == RdAddr_i))
        data_nxt = W0Data_i;
      else
        data_nxt = Rf_i[RdAddr_i];
    end
  end

  always_ff @(posedge Clk_i or negedge Rst_n_i) begin
    if (!Rst_n_i) begin
      RdData_o <= '0;
      RdBusy_o <= 1'b0;
    end else if (RdEn_i) begin
      RdData_o <= data_nxt;
      RdBusy_o <= busy_nxt;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: two write ports (W1 priority), NRP registered
// read ports with bypass, busy scoreboard. Ports: Clk_i, Rst_n_i, W0*/W1*
// write ports, IssueEn_i/IssueAddr_i, RsEn_i/RsAddr_i reads, RsData_o,
// RsBusy_o, BusyVec_o.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int REGAW    = REGAW_DEF,
  parameter int REGDW    = REGDW_DEF,
  parameter int REGN     = 2**REGAW,
  parameter int NRP      = NRP_DEF,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                 Clk_i,
  input  logic                 Rst_n_i,
  input  logic                 W0En_i,
  input  logic [REGAW-1:0]     W0Addr_i,
  input  logic [REGDW-1:0]     W0Data_i,
  input  logic                 W1En_i,
  input  logic [REGAW-1:0]     W1Addr_i,
  input  logic [REGDW-1:0]     W1Data_i,
  input  logic                 IssueEn_i,
  input  logic [REGAW-1:0]     IssueAddr_i,
  input  logic [NRP-1:0]       RsEn_i,
  input  logic [NRP*REGAW-1:0] RsAddr_i,
  output logic [NRP*REGDW-1:0] RsData_o,
  output logic [NRP-1:0]       RsBusy_o,
  output logic [REGN-1:0]      BusyVec_o
);

  logic [REGN-1:0][REGDW-1:0] rf;
  logic [REGN-1:0]            busy;
  logic [REGN-1:0]            busy_nxt;
  logic [REGN-1:0]            w0_hot;
  logic [REGN-1:0]            w1_hot;
  logic [REGN-1:0]            iss_hot;

  assign w0_hot  = REGN'(wr_onehot(W0En_i, MAX_AW'(W0Addr_i),
                                   REGN, ZERO_REG));
  assign w1_hot  = REGN'(wr_onehot(W1En_i, MAX_AW'(W1Addr_i),
                                   REGN, ZERO_REG));
  assign iss_hot = REGN'(wr_onehot(IssueEn_i, MAX_AW'(IssueAddr_i),
                                   REGN, ZERO_REG));

  always_ff @(posedge Clk_i or negedge Rst_n_i) begin
    if (!Rst_n_i) begin
      for (int i = 0; i < REGN; i++)
        rf[i] <= '0;
    end else begin
      for (int i = 0; i < REGN; i++) begin
        if (w1_hot[i])
          rf[i] <= W1Data_i;
        else if (w0_hot[i])
          rf[i] <= W0Data_i;
      end
    end
  end

  // Issue is applied after writeback clear: the issue is the newer event.
  always_comb begin
    busy_nxt = (busy & ~(w0_hot | w1_hot)) | iss_hot;
  end

  always_ff @(posedge Clk_i or negedge Rst_n_i) begin
    if (!Rst_n_i)
      busy <= '0;
    else
      busy <= busy_nxt;
  end

  assign BusyVec_o = busy;

  for (genvar k = 0; k < NRP; k++) begin : g_rd
    regfile_rd_port #(
      .REGAW    (REGAW),
      .REGDW    (REGDW),
      .REGN     (REGN),
      .ZERO_REG (ZERO_REG)
    ) u_rd (
      .Clk_i     (Clk_i),
      .Rst_n_i   (Rst_n_i),
      .RdEn_i    (RsEn_i[k]),
      .RdAddr_i  (RsAddr_i[k*REGAW +: REGAW]),
      .W0En_i    (W0En_i),
      .W0Addr_i  (W0Addr_i),
      .W0Data_i  (W0Data_i),
      .W1En_i    (W1En_i),
      .W1Addr_i  (W1Addr_i),
      .W1Data_i  (W1Data_i),
      .Rf_i      (rf),
      .BusyNxt_i (busy_nxt),
      .RdData_o  (RsData_o[k*REGDW +: REGDW]),
      .RdBusy_o  (RsBusy_o[k])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp.
// Two instances: default (zero reg on) and REGN=12 with zero reg off.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        w0e, w1e, ie;
  logic [3:0]  w0a, w1a, ia;
  logic [15:0] w0d, w1d;
  logic [1:0]  re;
  logic [7:0]  ra;

  logic [31:0] rd_a, rd_b;
  logic [1:0]  rb_a, rb_b;
  logic [15:0] bv_a;
  logic [11:0] bv_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_mp dut (
    .Clk_i(clk), .Rst_n_i(rst_n),
    .W0En_i(w0e), .W0Addr_i(w0a), .W0Data_i(w0d),
    .W1En_i(w1e), .W1Addr_i(w1a), .W1Data_i(w1d),
    .IssueEn_i(ie), .IssueAddr_i(ia),
    .RsEn_i(re), .RsAddr_i(ra),
    .RsData_o(rd_a), .RsBusy_o(rb_a), .BusyVec_o(bv_a)
  );

  regfile_mp #(.REGN(12), .ZERO_REG(1'b0)) dut0 (
    .Clk_i(clk), .Rst_n_i(rst_n),
    .W0En_i(w0e), .W0Addr_i(w0a), .W0Data_i(w0d),
    .W1En_i(w1e), .W1Addr_i(w1a), .W1Data_i(w1d),
    .IssueEn_i(ie), .IssueAddr_i(ia),
    .RsEn_i(re), .RsAddr_i(ra),
    .RsData_o(rd_b), .RsBusy_o(rb_b), .BusyVec_o(bv_b)
  );

  typedef struct {
    logic w0e; logic [3:0] w0a; logic [15:0] w0d;
    logic w1e; logic [3:0] w1a; logic [15:0] w1d;
    logic ie;  logic [3:0] ia;
    logic [1:0] re; logic [3:0] ra0, ra1;
    logic [15:0] d0; logic b0;
    logic [15:0] d1; logic b1;
    logic [15:0] bv;
  } vec_t;

  typedef struct {
    int which; int port; logic [15:0] data; logic busy;
  } exp_t;

  exp_t q[$];
  vec_t tbl[13];
  vec_t v;

  function automatic vec_t mk(
    logic a0, logic [3:0] a1, logic [15:0] a2,
    logic b0, logic [3:0] b1, logic [15:0] b2,
    logic c0, logic [3:0] c1,
    logic [1:0] r, logic [3:0] r0, logic [3:0] r1,
    logic [15:0] e0, logic f0, logic [15:0] e1, logic f1,
    logic [15:0] bv);
    vec_t t;
    t.w0e = a0; t.w0a = a1; t.w0d = a2;
    t.w1e = b0; t.w1a = b1; t.w1d = b2;
    t.ie = c0; t.ia = c1;
    t.re = r; t.ra0 = r0; t.ra1 = r1;
    t.d0 = e0; t.b0 = f0; t.d1 = e1; t.b1 = f1;
    t.bv = bv;
    return t;
  endfunction

  function automatic vec_t idle();
    return mk(0,0,0, 0,0,0, 0,0, 2'b00,0,0, 0,0,0,0, 0);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    w0e = t.w0e; w0a = t.w0a; w0d = t.w0d;
    w1e = t.w1e; w1a = t.w1a; w1d = t.w1d;
    ie = t.ie; ia = t.ia;
    re = t.re; ra = {t.ra1, t.ra0};
  endtask

  task automatic step(input vec_t t);
    exp_t e;
    logic [15:0] ad;
    logic ab;
    @(negedge clk);
    drive(t);
    if (t.re[0]) q.push_back('{0, 0, t.d0, t.b0});
    if (t.re[1]) q.push_back('{0, 1, t.d1, t.b1});
    @(posedge clk);
    #1;
    while (q.size() > 0) begin
      e = q.pop_front();
      if (e.which == 0) begin
        ad = rd_a[e.port*16 +: 16];
        ab = rb_a[e.port];
      end else begin
        ad = rd_b[e.port*16 +: 16];
        ab = rb_b[e.port];
      end
      chk($sformatf("dut%0d_p%0d_data", e.which, e.port),
          32'(ad), 32'(e.data));
      chk($sformatf("dut%0d_p%0d_busy", e.which, e.port),
          32'(ab), 32'(e.busy));
    end
    chk("busyvec", 32'(bv_a), 32'(t.bv));
  endtask

  initial begin
    rst_n = 1'b0;
    drive(idle());
    repeat (2) @(posedge clk);
    #1;
    chk("rst_data", rd_a, 32'h0);
    chk("rst_busy", 32'(rb_a), 32'h0);
    chk("rst_bv", 32'(bv_a), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    tbl[0]  = mk(1,3,16'h1234, 0,0,0, 0,0, 2'b00,0,0,
                 0,0, 0,0, 16'h0000);
    tbl[1]  = mk(0,0,0, 0,0,0, 0,0, 2'b01,3,0,
                 16'h1234,0, 0,0, 16'h0000);
    tbl[2]  = mk(1,5,16'hAAAA, 1,5,16'h5555, 0,0, 2'b10,0,5,
                 0,0, 16'h5555,0, 16'h0000);
    tbl[3]  = mk(0,0,0, 0,0,0, 0,0, 2'b01,5,0,
                 16'h5555,0, 0,0, 16'h0000);
    tbl[4]  = mk(1,7,16'hBEEF, 0,0,0, 0,0, 2'b10,0,7,
                 0,0, 16'hBEEF,0, 16'h0000);
    tbl[5]  = mk(0,0,0, 0,0,0, 1,4, 2'b01,4,0,
                 16'h0000,1, 0,0, 16'h0010);
    tbl[6]  = mk(0,0,0, 1,4,16'h0444, 1,4, 2'b10,0,4,
                 0,0, 16'h0444,1, 16'h0010);
    tbl[7]  = mk(1,4,16'h0555, 0,0,0, 0,0, 2'b01,4,0,
                 16'h0555,0, 0,0, 16'h0000);
    tbl[8]  = mk(1,8,16'h0001, 1,9,16'h0002, 0,0, 2'b11,8,9,
                 16'h0001,0, 16'h0002,0, 16'h0000);
    tbl[9]  = mk(0,0,0, 0,0,0, 0,0, 2'b11,9,8,
                 16'h0002,0, 16'h0001,0, 16'h0000);
    tbl[10] = mk(1,11,16'h0B0B, 0,0,0, 1,10, 2'b10,0,10,
                 0,0, 16'h0000,1, 16'h0400);
    tbl[11] = mk(1,10,16'h0A0A, 0,0,0, 1,12, 2'b01,10,0,
                 16'h0A0A,0, 0,0, 16'h1000);
    tbl[12] = mk(0,0,0, 1,12,16'hCCCC, 0,0, 2'b10,0,12,
                 0,0, 16'hCCCC,0, 16'h0000);

    for (int i = 0; i < 13; i++)
      step(tbl[i]);

    // zero register: write and issue r0 together
    v = idle();
    v.w0e = 1; v.w0a = 0; v.w0d = 16'hFFFF;
    v.ie = 1; v.ia = 0;
    step(v);
    chk("z_bv_dut0", 32'(bv_b), 32'h001);
    v = idle();
    v.re = 2'b01; v.ra0 = 0;
    v.d0 = 16'h0000; v.b0 = 0;
    q.push_back('{1, 0, 16'hFFFF, 1'b1});
    step(v);
    v = idle();
    v.w0e = 1; v.w0a = 0; v.w0d = 16'h0000;
    step(v);
    chk("z_clr_dut0", 32'(bv_b), 32'h000);

    // addresses beyond REGN=12 on dut0
    v = idle();
    v.w0e = 1; v.w0a = 14; v.w0d = 16'h7777;
    v.ie = 1; v.ia = 13;
    v.re = 2'b11; v.ra0 = 14; v.ra1 = 13;
    v.d0 = 16'h7777; v.b0 = 0; v.d1 = 16'h0000; v.b1 = 1;
    v.bv = 16'h2000;
    q.push_back('{1, 0, 16'h0000, 1'b0});
    q.push_back('{1, 1, 16'h0000, 1'b0});
    step(v);
    chk("oor_bv_dut0", 32'(bv_b), 32'h000);
    v = idle();
    v.w1e = 1; v.w1a = 13; v.w1d = 16'h1313;
    v.re = 2'b01; v.ra0 = 14;
    v.d0 = 16'h7777; v.b0 = 0;
    q.push_back('{1, 0, 16'h0000, 1'b0});
    step(v);

    // read enable hold
    v = idle();
    v.w0e = 1; v.w0a = 2; v.w0d = 16'h0042;
    v.re = 2'b01; v.ra0 = 2; v.d0 = 16'h0042;
    step(v);
    v = idle();
    v.w0e = 1; v.w0a = 2; v.w0d = 16'h0099;
    step(v);
    chk("hold_1", 32'(rd_a[15:0]), 32'h0042);
    step(idle());
    chk("hold_2", 32'(rd_a[15:0]), 32'h0042);
    v = idle();
    v.re = 2'b01; v.ra0 = 2; v.d0 = 16'h0099;
    step(v);

    // asynchronous reset in the middle of reads
    v = idle();
    v.ie = 1; v.ia = 6;
    v.re = 2'b11; v.ra0 = 3; v.ra1 = 6;
    v.d0 = 16'h1234; v.b0 = 0; v.d1 = 16'h0000; v.b1 = 1;
    v.bv = 16'h0040;
    step(v);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_data", rd_a, 32'h0);
    chk("arst_busy", 32'(rb_a), 32'h0);
    chk("arst_bv", 32'(bv_a), 32'h0);
    chk("arst_data_dut0", rd_b, 32'h0);
    @(posedge clk);
    @(negedge clk);
    drive(idle());
    rst_n = 1'b1;
    v = idle();
    v.re = 2'b01; v.ra0 = 3; v.d0 = 16'h0000;
    q.push_back('{1, 0, 16'h0000, 1'b0});
    step(v);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
